// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the core and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            i_start;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic            o_busy;
    logic            o_done;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    logic            o_rd_wren;

    modport master (
        output i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
        input  o_busy, o_done, o_rd_addr, o_rd_data, o_rd_wren
    );

    modport slave (
        input  i_start, i_funct3, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
        output o_busy, o_done, o_rd_addr, o_rd_data, o_rd_wren
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to resolve multiplies in one cycle with a 33x33 multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          state_q;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [4:0]      cnt_q;
    logic            neg_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] rd_data_q;
    logic [2*XLEN-1:0] acc_q;

    // Capture-side decode on the raw issue operands
    logic [2:0]      f;
    logic [XLEN-1:0] a, b, a_mag, b_mag, special_res;
    logic            sgn_a, sgn_b, neg_d, div_zero, div_ovf;

    always_comb begin
        f        = bus.i_funct3;
        a        = bus.i_rs1_data;
        b        = bus.i_rs2_data;
        sgn_a    = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
        sgn_b    = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
        a_mag    = (sgn_a && a[XLEN-1]) ? -a : a;
        b_mag    = (sgn_b && b[XLEN-1]) ? -b : b;
        // Remainders follow the dividend sign only; everything else is sign XOR.
        if (f[2] && f[1]) neg_d = sgn_a & a[XLEN-1];
        else              neg_d = (sgn_a & a[XLEN-1]) ^ (sgn_b & b[XLEN-1]);
        div_zero = f[2] && (b == '0);
        div_ovf  = ((f == 3'b100) || (f == 3'b110)) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (div_zero) special_res = f[1] ? a : '1;
        else          special_res = f[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_p;
    logic [XLEN-1:0]          fast_res;
    logic                     fast_unused;
    assign fast_p      = $signed({sgn_a & a[XLEN-1], a}) * $signed({sgn_b & b[XLEN-1], b});
    assign fast_res    = (f == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    assign fast_unused = ^fast_p[2*XLEN+1:2*XLEN];
`endif

    // One iteration step for either algorithm, plus the final sign-corrected result
    logic [XLEN:0]     mul_sum, div_pr, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_d, prod;
    logic [XLEN-1:0]   res_d, quot, rem;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_pr   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = div_pr >= {1'b0, opnd_q};
        div_diff = div_pr - {1'b0, opnd_q};
        if (op_q[2])
            acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_pr[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        prod = neg_q ? -acc_d : acc_d;
        quot = acc_d[XLEN-1:0];
        rem  = acc_d[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         res_d = prod[XLEN-1:0];
            3'b100, 3'b101: res_d = neg_q ? -quot : quot;
            3'b110, 3'b111: res_d = neg_q ? -rem : rem;
            default:        res_d = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            opnd_q    <= '0;
            rd_data_q <= '0;
            acc_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.i_start) begin
                    op_q  <= f;
                    rd_q  <= bus.i_rd_addr;
                    neg_q <= neg_d;
                    cnt_q <= '0;
                    if (div_zero || div_ovf) begin
                        rd_data_q <= special_res;
                        state_q   <= S_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!f[2]) begin
                        rd_data_q <= fast_res;
                        state_q   <= S_DONE;
                    end
`endif
                    else begin
                        // Multiply: multiplier in acc low half; divide: dividend there.
                        opnd_q  <= f[2] ? b_mag : a_mag;
                        acc_q   <= {{XLEN{1'b0}}, (f[2] ? a_mag : b_mag)};
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.i_flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            rd_data_q <= res_d;
                            state_q   <= S_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic done;
    assign done          = (state_q == S_DONE) && !bus.i_flush;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = done;
    assign bus.o_rd_addr = rd_q;
    assign bus.o_rd_data = rd_data_q;
    assign bus.o_rd_wren = done && (rd_q != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ps;
        longint unsigned ua, ub, pu;
        int ia, ib, r;
        logic ovf;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'b0, a};           ub = {32'b0, b};
        ia = a;                    ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin ps = sa * sb; return ps[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                r = ia / ib; return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                r = ia % ib; return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke);
        int n;
        bus.i_funct3 = f; bus.i_rs1_data = a; bus.i_rs2_data = b; bus.i_rd_addr = rd;
        bus.i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_start = 1'b0;
        bus.i_funct3 = 3'($urandom); bus.i_rs1_data = $urandom; bus.i_rs2_data = $urandom;
        bus.i_rd_addr = 5'($urandom);
        n = 1;
        chk("busy_rise", bus.o_busy, 1);
        while (!bus.o_done && n < 40) begin
            @(negedge i_clk);
            n++;
            bus.i_start = poke && (n == 3);
        end
        bus.i_start = 1'b0;
        chk($sformatf("lat f%0d", f), n, exp_lat(f, a, b));
        chk($sformatf("data f%0d %h %h", f, a, b), bus.o_rd_data, ref_op(f, a, b));
        chk("rd_addr", bus.o_rd_addr, rd);
        chk("wren", bus.o_rd_wren, rd != 0);
        @(negedge i_clk);
        chk("done_clr", bus.o_done, 0);
        chk("busy_fall", bus.o_busy, 0);
    endtask

    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [4:0] rd; } op_t;

    initial begin
        op_t dir[$];
        int  lat, hits;
        logic [31:0] ra, rb;

        bus.i_start = 0; bus.i_funct3 = 0; bus.i_rs1_data = 0; bus.i_rs2_data = 0;
        bus.i_rd_addr = 0; bus.i_flush = 0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_wren", bus.o_rd_wren, 0);
        chk("rst_rd_addr", bus.o_rd_addr, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        dir.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5});
        dir.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1});
        dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2});
        dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3});
        dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4});
        dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6});
        dir.push_back('{3'd5, 32'd100, 32'd7, 5'd7});
        dir.push_back('{3'd7, 32'd100, 32'd7, 5'd8});
        dir.push_back('{3'd4, 32'd5, 32'd0, 5'd9});
        dir.push_back('{3'd7, 32'd5, 32'd0, 5'd10});
        dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11});
        dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12});
        dir.push_back('{3'd0, 32'd123, 32'd456, 5'd0});
        foreach (dir[i]) run_op(dir[i].f, dir[i].a, dir[i].b, dir[i].rd, 1'b0);

        // Start while busy must be ignored
        run_op(3'd4, 32'd1000, 32'd3, 5'd13, 1'b1);
        run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 5'd14, 1'b1);

        // Flush mid-CALC at T+20
        bus.i_funct3 = 3'd5; bus.i_rs1_data = 32'd999; bus.i_rs2_data = 32'd4;
        bus.i_rd_addr = 5'd15; bus.i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_start = 1'b0;
        hits = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge i_clk);
            if (bus.o_done) hits++;
        end
        bus.i_flush = 1'b1;
        @(negedge i_clk);
        bus.i_flush = 1'b0;
        chk("flush_calc_idle", bus.o_busy, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (bus.o_done || bus.o_rd_wren) hits++;
        end
        chk("flush_calc_no_done", hits, 0);

        // Flush in DONE masks the write-back that same cycle
        lat = exp_lat(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        bus.i_funct3 = 3'd3; bus.i_rs1_data = 32'hDEAD_BEEF; bus.i_rs2_data = 32'h1234_5678;
        bus.i_rd_addr = 5'd16; bus.i_start = 1'b1;
        @(posedge i_clk);
        bus.i_start = 1'b0;
        repeat (lat) @(negedge i_clk);
        bus.i_flush = 1'b1;
        #1;
        chk("flush_done_mask", bus.o_done, 0);
        chk("flush_done_wren", bus.o_rd_wren, 0);
        @(negedge i_clk);
        bus.i_flush = 1'b0;
        chk("flush_done_idle", bus.o_busy, 0);

        // Async reset at T+10 of a DIV
        bus.i_funct3 = 3'd4; bus.i_rs1_data = 32'd1000; bus.i_rs2_data = 32'd3;
        bus.i_rd_addr = 5'd17; bus.i_start = 1'b1;
        @(posedge i_clk);
        bus.i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.o_busy, 0);
        chk("mid_rst_rd_data", bus.o_rd_data, 0);
        chk("mid_rst_rd_addr", bus.o_rd_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (bus.o_done || bus.o_rd_wren || bus.o_busy) hits++;
        end
        chk("mid_rst_no_wb", hits, 0);

        // Random sweep with boundary-biased operands
        for (int k = 0; k < 60; k++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 9);
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(3'($urandom), ra, rb, 5'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
